// File: rtl/dlatch_bank.sv
// Bank of NUM_CH independent WIDTH-bit capture registers with per-channel
// enable/clear and an optional shadow stage that publishes on a global commit.
module dlatch_bank #(
    parameter int              NUM_CH    = 4,
    parameter int              WIDTH     = 8,
    parameter int              MODE      = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int              OVF_W     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH*WIDTH-1:0]   data,
    input  logic [NUM_CH-1:0]         en,
    input  logic [NUM_CH-1:0]         clr,
    input  logic                      commit,
    output logic [NUM_CH*WIDTH-1:0]   q,
    output logic [NUM_CH-1:0]         q_valid,
    output logic [NUM_CH-1:0]         pending,
    output logic [NUM_CH*OVF_W-1:0]   ovf_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } ch_state_t;

    localparam logic [OVF_W-1:0] OVF_MAX = {OVF_W{1'b1}};

    if (MODE == 0) begin : g_direct
        // commit has no meaning without a shadow stage.
        logic unused_commit;
        assign unused_commit = commit;

        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic [WIDTH-1:0] q_r;
            logic             valid_r;

            always_ff @(posedge clk) begin
                if (reset || clr[c]) begin
                    q_r     <= RESET_VAL;
                    valid_r <= 1'b0;
                end else if (en[c]) begin
                    q_r     <= data[c*WIDTH +: WIDTH];
                    valid_r <= 1'b1;
                end
            end

            assign q[c*WIDTH +: WIDTH]     = q_r;
            assign q_valid[c]              = valid_r;
            assign pending[c]              = 1'b0;
            assign ovf_cnt[c*OVF_W +: OVF_W] = '0;
        end
    end else begin : g_shadow
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            ch_state_t        state;
            logic [WIDTH-1:0] shadow;
            logic [WIDTH-1:0] q_r;
            logic             valid_r;
            logic [OVF_W-1:0] cnt;

            // en+commit together writes straight through so the fresh word
            // lands in the same coherent snapshot as the other channels.
            always_ff @(posedge clk) begin
                if (reset || clr[c]) begin
                    state   <= IDLE;
                    shadow  <= RESET_VAL;
                    q_r     <= RESET_VAL;
                    valid_r <= 1'b0;
                    cnt     <= '0;
                end else if (en[c] && commit) begin
                    state   <= IDLE;
                    shadow  <= data[c*WIDTH +: WIDTH];
                    q_r     <= data[c*WIDTH +: WIDTH];
                    valid_r <= 1'b1;
                    cnt     <= '0;
                end else if (commit) begin
                    if (state == PEND) begin
                        state   <= IDLE;
                        q_r     <= shadow;
                        valid_r <= 1'b1;
                        cnt     <= '0;
                    end
                end else if (en[c]) begin
                    shadow <= data[c*WIDTH +: WIDTH];
                    state  <= PEND;
                    if (state == PEND && cnt != OVF_MAX) begin
                        cnt <= cnt + OVF_W'(1);
                    end
                end
            end

            assign q[c*WIDTH +: WIDTH]       = q_r;
            assign q_valid[c]                = valid_r;
            assign pending[c]                = (state == PEND);
            assign ovf_cnt[c*OVF_W +: OVF_W] = cnt;
        end
    end

endmodule

// File: tb/tb_dlatch_bank.sv
// Directed bench for dlatch_bank: one direct-mode and one shadow-mode instance
// driven from hand-computed vectors.
module tb_dlatch_bank;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:0] d_data;
    logic [3:0]  d_en, d_clr;
    logic        d_commit;
    logic [31:0] d_q;
    logic [3:0]  d_q_valid, d_pending;
    logic [15:0] d_ovf;

    logic [31:0] s_data;
    logic [3:0]  s_en, s_clr;
    logic        s_commit;
    logic [31:0] s_q;
    logic [3:0]  s_q_valid, s_pending;
    logic [7:0]  s_ovf;

    int n_vec = 0;
    int n_err = 0;

    dlatch_bank #(.NUM_CH(4), .WIDTH(8), .MODE(0), .RESET_VAL(8'h00), .OVF_W(4)) u_direct (
        .clk(clk), .reset(reset), .data(d_data), .en(d_en), .clr(d_clr),
        .commit(d_commit), .q(d_q), .q_valid(d_q_valid), .pending(d_pending),
        .ovf_cnt(d_ovf)
    );

    dlatch_bank #(.NUM_CH(4), .WIDTH(8), .MODE(1), .RESET_VAL(8'hA5), .OVF_W(2)) u_shadow (
        .clk(clk), .reset(reset), .data(s_data), .en(s_en), .clr(s_clr),
        .commit(s_commit), .q(s_q), .q_valid(s_q_valid), .pending(s_pending),
        .ovf_cnt(s_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just past it, so outputs are sampled and
    // new inputs are driven away from the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_s(input logic [3:0] en, input logic [31:0] data,
                           input logic commit, input logic [3:0] clr);
        s_en = en; s_data = data; s_commit = commit; s_clr = clr;
    endtask

    initial begin
        reset = 1'b1;
        d_data = '0; d_en = '0; d_clr = '0; d_commit = 1'b0;
        s_data = '0; s_en = '0; s_clr = '0; s_commit = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("d_reset_q", d_q, 32'h0000_0000);
        check("d_reset_valid", {28'd0, d_q_valid}, 32'd0);
        check("s_reset_q", s_q, 32'hA5A5_A5A5);
        check("s_reset_valid", {28'd0, s_q_valid}, 32'd0);
        check("s_reset_pending", {28'd0, s_pending}, 32'd0);
        check("s_reset_ovf", {24'd0, s_ovf}, 32'd0);

        // Direct mode
        d_en = 4'b0010; d_data = 32'h0000_3C00;
        step();
        d_en = 4'b0000; d_data = 32'hFFFF_FFFF;
        check("d_cap_q", d_q, 32'h0000_3C00);
        check("d_cap_valid", {28'd0, d_q_valid}, 32'h2);
        check("d_pending", {28'd0, d_pending}, 32'd0);
        step();
        check("d_hold_q", d_q, 32'h0000_3C00);
        d_en = 4'b1001; d_data = 32'h12FF_FF34;
        step();
        check("d_cap2_q", d_q, 32'h1200_3C34);
        check("d_cap2_valid", {28'd0, d_q_valid}, 32'hB);
        d_en = 4'b0010; d_clr = 4'b0010; d_data = 32'h0000_9900;
        step();
        d_en = 4'b0000; d_clr = 4'b0000;
        check("d_clr_q", d_q, 32'h1200_0034);
        check("d_clr_valid", {28'd0, d_q_valid}, 32'h9);
        check("d_ovf", {16'd0, d_ovf}, 32'd0);

        // Coherent commit
        drive_s(4'b0001, 32'h0000_0011, 1'b0, 4'b0000);
        step();
        check("coh_c1_pending", {28'd0, s_pending}, 32'h1);
        check("coh_c1_q", s_q, 32'hA5A5_A5A5);
        drive_s(4'b0000, 32'h0, 1'b0, 4'b0000);
        step();
        drive_s(4'b0100, 32'h0022_0000, 1'b0, 4'b0000);
        step();
        drive_s(4'b0000, 32'h0, 1'b0, 4'b0000);
        step();
        check("coh_c4_pending", {28'd0, s_pending}, 32'h5);
        check("coh_c4_q", s_q, 32'hA5A5_A5A5);
        drive_s(4'b0000, 32'h0, 1'b1, 4'b0000);
        step();
        check("coh_pub_q", s_q, 32'hA522_A511);
        check("coh_pub_valid", {28'd0, s_q_valid}, 32'h5);
        check("coh_pub_pending", {28'd0, s_pending}, 32'd0);
        step();
        step();
        drive_s(4'b0000, 32'h0, 1'b0, 4'b0000);
        check("idle_commit_q", s_q, 32'hA522_A511);
        check("idle_commit_ovf", {24'd0, s_ovf}, 32'd0);

        // Overrun saturation on channel 3
        drive_s(4'b1000, 32'h3100_0000, 1'b0, 4'b0000);
        step();
        check("ovf_e1", {30'd0, s_ovf[7:6]}, 32'd0);
        for (int i = 2; i <= 6; i++) begin
            drive_s(4'b1000, {8'(8'h30 + i), 24'h0}, 1'b0, 4'b0000);
            step();
            check($sformatf("ovf_e%0d", i), {30'd0, s_ovf[7:6]}, (i >= 4) ? 32'd3 : 32'(i - 1));
        end
        check("ovf_q_unpub", s_q, 32'hA522_A511);
        drive_s(4'b0000, 32'h0, 1'b1, 4'b0000);
        step();
        check("ovf_commit_cnt", {24'd0, s_ovf}, 32'd0);
        check("ovf_commit_q", s_q, 32'h3622_A511);
        check("ovf_commit_valid", {28'd0, s_q_valid}, 32'hD);

        // Simultaneous events
        drive_s(4'b0010, 32'h0000_5500, 1'b1, 4'b0000);
        step();
        check("wt_q", s_q, 32'h3622_5511);
        check("wt_valid", {28'd0, s_q_valid}, 32'hF);
        drive_s(4'b0011, 32'h0000_7701, 1'b0, 4'b0000);
        step();
        check("sim_pend", {28'd0, s_pending}, 32'h3);
        check("sim_q_hold", s_q, 32'h3622_5511);
        drive_s(4'b0011, 32'h0000_FF02, 1'b1, 4'b0010);
        step();
        drive_s(4'b0000, 32'h0, 1'b0, 4'b0000);
        check("sim_q", s_q, 32'h3622_A502);
        check("sim_valid", {28'd0, s_q_valid}, 32'hD);
        check("sim_pending", {28'd0, s_pending}, 32'd0);
        check("sim_ovf", {24'd0, s_ovf}, 32'd0);

        // Reset mid-stream
        drive_s(4'b0001, 32'h0000_00EE, 1'b0, 4'b0000);
        step();
        check("mid_pend", {28'd0, s_pending}, 32'h1);
        drive_s(4'b0000, 32'h0, 1'b1, 4'b0000);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_q", s_q, 32'hA5A5_A5A5);
        check("mid_rst_pending", {28'd0, s_pending}, 32'd0);
        check("mid_rst_valid", {28'd0, s_q_valid}, 32'd0);
        check("mid_rst_dq", d_q, 32'h0000_0000);
        drive_s(4'b0001, 32'h0000_007E, 1'b0, 4'b0000);
        step();
        check("post_rst_pend", {28'd0, s_pending}, 32'h1);
        drive_s(4'b0000, 32'h0, 1'b1, 4'b0000);
        step();
        drive_s(4'b0000, 32'h0, 1'b0, 4'b0000);
        check("post_rst_q", s_q, 32'hA5A5_A57E);
        check("post_rst_valid", {28'd0, s_q_valid}, 32'h1);
        check("post_rst_pending", {28'd0, s_pending}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dlatch_bank.md
# dlatch_bank

Parametrised bank of NUM_CH independent WIDTH-bit capture registers. It is the clocked, multi-channel successor to the single-bit reset-able data latch. Each channel captures its data word under a per-channel enable. In shadow mode, captures are staged and published to all outputs at once on a commit strobe, and per-channel overrun counters flag captures that were lost before a commit. The block sits between asynchronous-ish control sources (already synchronised to clk) and downstream logic that needs coherent multi-channel snapshots.

## Interface
- NUM_CH, 4: number of channels, ≥1
- WIDTH, 8: data bits per channel, ≥1
- MODE, 0: 0 = direct capture; 1 = shadow/commit capture
- RESET_VAL, 0: value loaded into every q and shadow word on reset or clear (WIDTH bits, same for all channels)
- OVF_W, 4: width of each overrun counter, ≥1

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- data  input  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- en  input  NUM_CH  per-channel capture enable
- clr  input  NUM_CH  per-channel synchronous clear
- commit  input  1  publish strobe; ignored when MODE=0
- q  output  NUM_CH*WIDTH  published channel values, registered
- q_valid  output  NUM_CH  channel has published a captured value since last reset/clear
- pending  output  NUM_CH  shadow holds an unpublished capture; constant 0 when MODE=0
- ovf_cnt  output  NUM_CH*OVF_W  per-channel saturating overrun count; constant 0 when MODE=0

## Operation
- Reset (reset=1 at a clk edge): all q and shadow words = RESET_VAL; q_valid, pending and ovf_cnt = 0. Reset overrides every other input.
- Priority per channel, highest first: reset > clr[c] > capture/commit.
- clr[c]=1: q[c] and shadow[c] = RESET_VAL; q_valid[c], pending[c] and ovf_cnt[c] = 0. Any en[c] or commit in the same cycle has no effect on channel c. Other channels commit normally.
- MODE=0:
  - en[c]=1 → q[c] = data[c] and q_valid[c] = 1 at the next edge.
  - en[c]=0 → q[c] holds its value.
- MODE=1, per channel, states IDLE (pending=0) and PEND (pending=1):
  - IDLE, en, no commit → shadow = data; go to PEND.
  - PEND, en, no commit → shadow overwritten; ovf_cnt increments, saturating at 2^OVF_W−1; stay in PEND.
  - PEND, commit, no en → q = shadow; q_valid = 1; ovf_cnt = 0; go to IDLE.
  - en and commit in the same cycle (either state) → write-through: q = data and shadow = data; q_valid = 1; ovf_cnt = 0; go to IDLE. No overrun is counted.
  - IDLE, commit, no en → no change to that channel.
  - No en, no commit → hold.
- Commit is global. Every channel that is PEND or has en asserted publishes at the same edge, so q is always a coherent snapshot.
- Channels are fully independent apart from the shared commit.

## Timing
- All outputs are registered; no combinational path from input to output.
- Latency: en or commit sampled at edge N → q, q_valid, pending and ovf_cnt updated after edge N and visible in cycle N+1.
- commit is level-sampled each cycle. Holding it high for k cycles is k commits, and repeated commits with nothing pending are harmless.
- Reset applied mid-operation discards pending shadows and counts in the same edge. The first capture is accepted at the edge after reset deasserts.
- ovf_cnt arithmetic is unsigned OVF_W-bit and saturates, never wraps.

## Test plan
- Reset: MODE=1, RESET_VAL=8'hA5; load all channels, then assert reset for 1 cycle → next cycle every q=8'hA5, q_valid=0, pending=0, ovf_cnt=0.
- Direct mode: MODE=0; en=4'b0010 with ch1 data=8'h3C → q ch1=8'h3C and q_valid=4'b0010 one cycle later; other channels unchanged; pending stays 0.
- Coherent commit: MODE=1; en ch0=8'h11 in cycle 1, ch2=8'h22 in cycle 3, commit in cycle 5 → q unchanged through cycle 5, pending=4'b0101; in cycle 6 ch0=8'h11, ch2=8'h22 together and pending=0.
- Overrun saturation: OVF_W=2; en ch3 for 6 consecutive cycles with no commit → ovf_cnt ch3 reads 1, 2, 3, 3, 3; commit → ovf_cnt ch3=0 and q ch3 = the last data written.
- Simultaneous events: ch0 PEND with shadow 8'h01; en ch0 data=8'h02 together with commit → q ch0=8'h02, pending=0, ovf_cnt unchanged at 0. Same cycle, clr ch1 with en ch1 → q ch1=RESET_VAL, q_valid ch1=0.
- Reset mid-stream: ch0 PEND; reset and commit in the same cycle → q ch0=RESET_VAL, pending=0. Then en ch0=8'h7E followed by commit → q ch0=8'h7E.
